// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: AND/OR/ADD/SUB/SLT/NOR with zero/overflow/carry flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_full;
    logic             ovf;

    always_comb begin
        sub       = (alu_ctrl == OP_SUB) | (alu_ctrl == OP_SLT);
        b_eff     = sub ? ~b : b;
        sum_full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        ovf       = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum_full[WIDTH-1] != a[WIDTH-1]);
        y         = '0;
        overflow  = 1'b0;
        carry_out = 1'b0;
        case (alu_ctrl)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_NOR: y = ~(a | b);
            OP_ADD, OP_SUB: begin
                y         = sum_full[WIDTH-1:0];
                overflow  = ovf;
                carry_out = sum_full[WIDTH];
            end
            // Sign of a-b corrected by overflow gives the true signed compare
            OP_SLT: y = {{(WIDTH-1){1'b0}}, sum_full[WIDTH-1] ^ ovf};
            default: y = '0;
        endcase
        zero = (y == '0);
    end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Defining ALU_DIV_EN adds a restoring divider (DIVU) sharing the BUSY state and counter.
module mc_alu
    import alu_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d, res_hi_q, res_hi_d;
    logic               zero_q, zero_d, ovf_q, ovf_d, carry_q, carry_d;

    logic [WIDTH-1:0]   core_y;
    logic               core_zero, core_ovf, core_carry;
    logic               transfer, is_mul, is_div;
    logic [WIDTH:0]     mul_sum;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a        (a),
        .b        (b),
        .alu_ctrl (alu_ctrl),
        .y        (core_y),
        .zero     (core_zero),
        .overflow (core_ovf),
        .carry_out(core_carry)
    );

    assign is_mul = (alu_ctrl == OP_MULU);

`ifdef ALU_DIV_EN
    logic           div_q, div_d;
    logic [WIDTH:0] div_rs, div_diff;

    assign is_div = (alu_ctrl == OP_DIVU);
`else
    assign is_div = 1'b0;
`endif

    // acc holds {high/remainder, low/multiplier/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        acc_step = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_rs   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_rs - {1'b0, opnd_q};
        if (div_q) begin
            // b == 0 never borrows, so quotient fills with ones and a shifts into remainder
            acc_step = div_diff[WIDTH] ? {div_rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        carry_d  = carry_q;
`ifdef ALU_DIV_EN
        div_d    = div_q;
`endif
        in_ready = ~rst & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
        transfer = in_valid & in_ready;

        case (state_q)
            S_BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_DONE;
                    res_d    = acc_step[WIDTH-1:0];
                    res_hi_d = acc_step[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_step[WIDTH-1:0] == '0);
                    ovf_d    = 1'b0;
                    carry_d  = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            S_IDLE: ;
            default: state_d = S_IDLE;
        endcase

        // A transfer in DONE overrides the drain-to-IDLE above
        if (transfer) begin
            if (is_mul | is_div) begin
                state_d = S_BUSY;
                cnt_d   = CNT_W'(WIDTH);
                opnd_d  = is_div ? b : a;
                acc_d   = {{WIDTH{1'b0}}, is_div ? a : b};
`ifdef ALU_DIV_EN
                div_d   = is_div;
`endif
            end else begin
                state_d  = S_DONE;
                res_d    = core_y;
                res_hi_d = '0;
                zero_d   = core_zero;
                ovf_d    = core_ovf;
                carry_d  = core_carry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            carry_q  <= carry_d;
        end
    end

`ifdef ALU_DIV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= 1'b0;
        else     div_q <= div_d;
    end
`endif

    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign result_hi = res_hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign carry_out = carry_q;

endmodule

// File: doc/mc_alu.md
Name: mc_alu

Overview:
- Parametrised multi-cycle ALU, WIDTH bits wide, with a valid/ready handshake on input and output.
- Single-cycle datapath for AND/OR/ADD/SUB/SLT/NOR; iterative shift-add unsigned multiplier producing a 2*WIDTH result.
- Successor to the per-bit ALU slice; sits between the decode/ALU-control stage and writeback in the multi-cycle CPU.

Parameters:
- WIDTH, 32, operand/result width; legal range 2..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; transfer when in_valid & in_ready.
- a  in  WIDTH  operand A, captured on transfer.
- b  in  WIDTH  operand B, captured on transfer.
- alu_ctrl  in  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MULU, 1001 DIVU (optional).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
- result  out  WIDTH  low word / quotient / logic result.
- result_hi  out  WIDTH  MULU high word, DIVU remainder, 0 for other ops.
- zero  out  1  result == 0 (low word only).
- overflow  out  1  signed overflow for ADD/SUB, 0 otherwise.
- carry_out  out  1  carry from MSB for ADD/SUB (SUB: 1 = no borrow), 0 otherwise.

Behaviour:
- States: IDLE, BUSY, DONE. Reset → IDLE; all outputs 0, except in_ready = 1 once rst is low.
- Datapath width: a, b and the internal accumulator are registered at transfer; input changes after transfer are ignored.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This allows back-to-back accept in the cycle the previous result drains.
- Single-cycle ops: accept → DONE on the next edge; out_valid rises 1 cycle after transfer.
- SUB is a + ~b + 1.
- SLT: result = {0…, sum[MSB] ^ ovf}, where sum/ovf come from a-b; overflow and carry_out reported as 0.
- NOR = ~(a|b).
- MULU: accept → BUSY with counter = WIDTH. Each cycle, add the multiplicand if the multiplier LSB is 1, then shift right.
  - Counter hits 0 → DONE; out_valid rises exactly WIDTH+1 cycles after transfer.
  - in_ready = 0 throughout BUSY.
- Illegal opcode: single-cycle path; result = 0, result_hi = 0, zero = 1, flags 0.
- DONE: outputs held stable while out_ready = 0.
  - out_ready & !in_valid → IDLE, out_valid drops next cycle.
  - out_ready & in_valid → accept the new op in the same cycle.
- Reset asserted mid-operation (any state) aborts immediately and asynchronously: out_valid = 0, state IDLE, accumulator cleared. No partial result is ever presented.
- Output registers (result, result_hi, flags) update only on entry to DONE.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: opcode 1001 DIVU runs a restoring divider sharing the BUSY state and counter; latency WIDTH+1.
  - result = a / b, result_hi = a % b.
  - b == 0 → result = all ones, result_hi = a, with the same latency.
- Undefined: 1001 is an illegal opcode (result 0, zero 1); no divider logic is synthesised.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MULU, OP_DIVU);
  - state typedef (S_IDLE, S_BUSY, S_DONE).
- Sub-module alu_core: purely combinational WIDTH-bit AND/OR/ADD/SUB/SLT/NOR with zero/overflow/carry_out. mc_alu instantiates it and owns the FSM, handshake and iterative unit.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, carry_out 0, zero 0; out_valid exactly 1 cycle after transfer.
- SUB 5 - 5 → result 0, zero 1, carry_out 1.
  - SLT 0xFFFFFFFF vs 0x00000001 → 1.
  - SLT 0x80000000 vs 0x00000001 → 1 (overflow-corrected).
  - SLT 1 vs 0xFFFFFFFF → 0.
- MULU 0xFFFFFFFF × 0x00000002 → result_hi 0x00000001, result 0xFFFFFFFE; out_valid 33 cycles after transfer; in_ready 0 during BUSY; mid-BUSY changes on a/b ignored.
- Backpressure: complete AND, hold out_ready = 0 for 5 cycles → result stable, in_ready 0. Then assert out_ready & in_valid (OR op) together → both transfers in one cycle; OR result valid on the next cycle.
- Reset: assert rst in BUSY cycle 10 of a MULU → out_valid 0 and in_ready 0 while asserted. After release, in_ready 1 and ADD 3+4 → 7.
- ALU_DIV_EN on: DIVU 100/7 → result 14, result_hi 2; DIVU 9/0 → result 0xFFFFFFFF, result_hi 9, latency 33. Off: opcode 1001 → result 0, zero 1, latency 1.
